// File: rtl/sirv_gnrl_fifo_ptr.sv
// Wrap-around pointer register for the FIFO. It advances by one when inc_i is high,
// and it returns from DP-1 to 0 by comparison, so DP need not be a power of two.
module sirv_gnrl_fifo_ptr #(
  parameter int DP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_i,
  output logic [$clog2(DP)-1:0] ptr_o
);

  localparam int PW = $clog2(DP);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer value: wrap at the last entry, otherwise increment.
  always_comb begin
    ptr_d = (ptr_q == PW'(DP - 1)) ? '0 : ptr_q + 1'b1;
  end

  // Pointer register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (inc_i) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sirv_gnrl_fifo_rv.sv
// Synchronous valid/ready FIFO. Words are pushed with i_vld/i_rdy and drained in
// order with o_vld/o_rdy. The ready and valid flags are decoded only from the
// registered occupancy, so no combinational path runs from o_rdy to i_rdy.
//
// Handshake semantics: a transfer happens on a rising edge exactly when valid and
// ready are both high in the cycle before that edge. The producer holds i_dat
// stable while i_vld is high. The FIFO drives o_dat with the head word whenever
// o_vld is high. Neither side may make valid depend combinationally on ready.
module sirv_gnrl_fifo_rv #(
  parameter  int DW = 32,
  parameter  int DP = 4,
  localparam int CW = $clog2(DP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DP);

  logic [DW-1:0] mem_q [DP];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push;
  logic          pop;

  assign full  = (cnt_q == CW'(DP));
  assign empty = (cnt_q == '0);
  assign i_rdy = ~full;
  assign o_vld = ~empty;
  assign push  = i_vld & i_rdy;
  assign pop   = o_vld & o_rdy;
  assign cnt   = cnt_q;
  assign o_dat = mem_q[rptr];

  sirv_gnrl_fifo_ptr #(.DP(DP)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (push),
    .ptr_o (wptr)
  );

  sirv_gnrl_fifo_ptr #(.DP(DP)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pop),
    .ptr_o (rptr)
  );

  // Storage: clear all entries on reset, otherwise write the tail slot on push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DP; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wptr] <= i_dat;
    end
  end

  // Occupancy next state: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef SIMULATION
  logic rst_seen;

  // Sanity checks once the block has seen at least one reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      rst_seen <= 1'b1;
    end else if (rst_seen) begin
      assert (cnt_q <= CW'(DP)) else $error("occupancy above depth: %0d", cnt_q);
      assert (!$isunknown({i_vld, o_rdy})) else $error("unknown handshake input");
    end
  end
`endif

endmodule

// File: tb/tb_sirv_gnrl_fifo_rv.sv
// Bench for sirv_gnrl_fifo_rv: directed phases on a depth-4 instance, followed by
// random traffic on depth-4 and depth-3 instances at the same time.
module tb_sirv_gnrl_fifo_rv;

  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // depth-4 instance
  logic          i_vld = 1'b0;
  logic          i_rdy;
  logic [DW-1:0] i_dat = '0;
  logic          o_vld;
  logic          o_rdy = 1'b0;
  logic [DW-1:0] o_dat;
  logic [2:0]    cnt;
  logic          full;
  logic          empty;

  // depth-3 instance
  logic          i3_vld = 1'b0;
  logic          i3_rdy;
  logic [DW-1:0] i3_dat = '0;
  logic          o3_vld;
  logic          o3_rdy = 1'b0;
  logic [DW-1:0] o3_dat;
  logic [1:0]    cnt3;
  logic          full3;
  logic          empty3;

  sirv_gnrl_fifo_rv #(.DW(DW), .DP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .cnt(cnt), .full(full), .empty(empty)
  );

  sirv_gnrl_fifo_rv #(.DW(DW), .DP(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_vld(i3_vld), .i_rdy(i3_rdy), .i_dat(i3_dat),
    .o_vld(o3_vld), .o_rdy(o3_rdy), .o_dat(o3_dat), .cnt(cnt3), .full(full3), .empty(empty3)
  );

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp3_q[$];
  logic [DW-1:0] got_q[$];
  int m_cnt = 0;
  int m3_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- monitor: depth-4 model ----------------
  always @(negedge clk) begin
    logic p, q;
    if (!rst_n) begin
      m_cnt = 0;
      exp_q.delete();
    end else begin
      chk("cnt4", 64'(cnt), 64'(m_cnt));
      chk("i_rdy4", 64'(i_rdy), 64'(m_cnt < 4));
      chk("o_vld4", 64'(o_vld), 64'(m_cnt > 0));
      chk("full4", 64'(full), 64'(m_cnt == 4));
      chk("empty4", 64'(empty), 64'(m_cnt == 0));
      p = i_vld && (m_cnt < 4);
      q = o_rdy && (m_cnt > 0);
      if (q) begin
        got_q.push_back(o_dat);
        if (exp_q.size() == 0) chk("pop4_underflow", 64'(o_dat), 64'hDEAD_0000);
        else chk("o_dat4", 64'(o_dat), 64'(exp_q.pop_front()));
      end
      if (p) exp_q.push_back(i_dat);
      m_cnt = m_cnt + int'(p) - int'(q);
    end
  end

  // ---------------- monitor: depth-3 model ----------------
  always @(negedge clk) begin
    logic p, q;
    if (!rst_n) begin
      m3_cnt = 0;
      exp3_q.delete();
    end else begin
      chk("cnt3", 64'(cnt3), 64'(m3_cnt));
      chk("cnt3_range", 64'(cnt3 <= 2'd3), 64'd1);
      chk("i_rdy3", 64'(i3_rdy), 64'(m3_cnt < 3));
      chk("o_vld3", 64'(o3_vld), 64'(m3_cnt > 0));
      p = i3_vld && (m3_cnt < 3);
      q = o3_rdy && (m3_cnt > 0);
      if (q) begin
        if (exp3_q.size() == 0) chk("pop3_underflow", 64'(o3_dat), 64'hDEAD_0000);
        else chk("o_dat3", 64'(o3_dat), 64'(exp3_q.pop_front()));
      end
      if (p) exp3_q.push_back(i3_dat);
      m3_cnt = m3_cnt + int'(p) - int'(q);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    i_vld = v;
    i_dat = d;
    o_rdy = r;
  endtask

  task automatic chk_got(input string name, input logic [DW-1:0] want[$]);
    chk({name, "_len"}, 64'(got_q.size()), 64'(want.size()));
    for (int i = 0; i < want.size() && i < got_q.size(); i++) begin
      chk(name, 64'(got_q[i]), 64'(want[i]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] want[$];

    // Reset then idle.
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_o_vld", 64'(o_vld), 64'd0);
      chk("idle_i_rdy", 64'(i_rdy), 64'd1);
      chk("idle_cnt", 64'(cnt), 64'd0);
      chk("idle_empty", 64'(empty), 64'd1);
      chk("idle_full", 64'(full), 64'd0);
      chk("idle_o_dat", 64'(o_dat), 64'd0);
    end

    // Fill with A0..A3, offer FF while full, then drain.
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(32'hA0 + i), 1'b0);
      step();
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_i_rdy", 64'(i_rdy), 64'd0);
    chk("fill_cnt", 64'(cnt), 64'd4);
    drive(1'b1, 32'hFF, 1'b0);
    step();
    chk("reject_cnt", 64'(cnt), 64'd4);
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("drain_empty", 64'(empty), 64'd1);
    drive(1'b0, 32'h0, 1'b0);
    step();
    want = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    chk_got("drain_order", want);

    // Full with o_rdy=1: pop only.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(32'hE0 + i), 1'b0);
      step();
    end
    chk("full2_cnt", 64'(cnt), 64'd4);
    drive(1'b1, 32'hE4, 1'b1);
    step();
    chk("full_pop_cnt", 64'(cnt), 64'd3);
    chk("full_pop_i_rdy", 64'(i_rdy), 64'd1);
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("full_drain_cnt", 64'(cnt), 64'd0);

    // Empty with push and pop requested together.
    got_q.delete();
    drive(1'b1, 32'h55, 1'b1);
    chk("emp_o_vld_same", 64'(o_vld), 64'd0);
    step();
    drive(1'b0, 32'h0, 1'b1);
    chk("emp_o_vld_next", 64'(o_vld), 64'd1);
    chk("emp_o_dat_next", 64'(o_dat), 64'h55);
    chk("emp_cnt_1", 64'(cnt), 64'd1);
    step();
    chk("emp_cnt_0", 64'(cnt), 64'd0);
    want = '{32'h55};
    chk_got("emp_order", want);
    drive(1'b0, 32'h0, 1'b0);

    // Streaming at cnt=2: 20 words in and out with both sides active.
    got_q.delete();
    drive(1'b1, 32'hC0, 1'b0); step();
    drive(1'b1, 32'hC1, 1'b0); step();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, DW'(32'hD0 + i), 1'b1);
      step();
      chk("stream_cnt", 64'(cnt), 64'd2);
    end
    drive(1'b0, 32'h0, 1'b1);
    step(); step();
    drive(1'b0, 32'h0, 1'b0);
    chk("stream_empty", 64'(empty), 64'd1);
    want = '{32'hC0, 32'hC1};
    for (int i = 0; i < 20; i++) want.push_back(DW'(32'hD0 + i));
    chk_got("stream_order", want);

    // Reset in the middle of operation at cnt=3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(32'h31 + i), 1'b0);
      step();
    end
    chk("pre_rst_cnt", 64'(cnt), 64'd3);
    rst_n = 1'b0;
    drive(1'b1, 32'h99, 1'b0);
    step();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_o_vld", 64'(o_vld), 64'd0);
    chk("rst_i_rdy", 64'(i_rdy), 64'd1);
    chk("rst_o_dat", 64'(o_dat), 64'd0);
    got_q.delete();
    drive(1'b1, 32'h77, 1'b0); step();
    drive(1'b0, 32'h0, 1'b1); step();
    drive(1'b0, 32'h0, 1'b0);
    want = '{32'h77};
    chk_got("rst_first_word", want);

    // Random traffic on both depths.
    for (int i = 0; i < 10000; i++) begin
      i_vld  = 1'($urandom_range(0, 1));
      i_dat  = DW'($urandom);
      o_rdy  = 1'($urandom_range(0, 1));
      i3_vld = 1'($urandom_range(0, 1));
      i3_dat = DW'($urandom);
      o3_rdy = 1'($urandom_range(0, 1));
      step();
    end

    // Drain both and confirm nothing was left behind.
    i_vld = 1'b0;
    i3_vld = 1'b0;
    o_rdy = 1'b1;
    o3_rdy = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("final_empty4", 64'(empty), 64'd1);
    chk("final_empty3", 64'(empty3), 64'd1);
    chk("final_q4", 64'(exp_q.size()), 64'd0);
    chk("final_q3", 64'(exp3_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sirv_gnrl_fifo_rv.md
Name: sirv_gnrl_fifo_rv

Overview:
Synchronous valid/ready FIFO. It is the consumer-side counterpart to the load-enable register primitives: a producer pushes words with a handshake, and a reader drains them in order with a handshake. It is used between pipeline stages and as a decoupling buffer, for example for instruction fetch responses and writeback queues. All state is registered, and there is no combinational path from o_rdy to i_rdy.

Parameters:
- DW, 32, data width in bits.
- DP, 4, depth in entries. DP must be at least 2; it need not be a power of two.
- CW, $clog2(DP+1), occupancy count width. This is derived and must not be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- i_vld  input  1  producer has a word on i_dat.
- i_rdy  output  1  FIFO can accept a word this cycle.
- i_dat  input  DW  write data.
- o_vld  output  1  FIFO holds at least one word.
- o_rdy  input  1  reader takes the head word this cycle.
- o_dat  output  DW  head word.
- cnt  output  CW  current occupancy, 0..DP.
- full  output  1  cnt == DP.
- empty  output  1  cnt == 0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - wptr, rptr and cnt are cleared to 0; all storage entries are cleared to 0.
  - Resulting outputs: o_vld=0, i_rdy=1, o_dat=0, empty=1, full=0.
  - Reset takes priority over any push or pop in the same cycle. Words in flight mid-operation are discarded.
- Handshakes:
  - push = i_vld & i_rdy.
  - pop = o_vld & o_rdy.
  - i_rdy = ~full and o_vld = ~empty. Both are decoded from registered cnt only.
- Push: mem[wptr] <= i_dat. wptr advances by 1, and wraps from DP-1 to 0 by compare, not by masking.
- Pop: rptr advances by 1 with the same wrap rule.
- o_dat = mem[rptr], read combinationally from storage. It is meaningful only when o_vld=1. When empty it shows the stale or reset content, and the bench must not check it.
- Count update:
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop together: cnt unchanged, and both pointers advance.
- Latency: a word pushed at edge N is visible on o_vld/o_dat after edge N. Minimum push-to-pop latency is one cycle; there is no same-cycle bypass.
- Full: i_rdy=0, so a push is impossible even if o_rdy=1 in that cycle. A pop while full frees a slot, and i_rdy=1 from the next cycle.
- Empty: o_vld=0, so a pop is impossible. A push while empty with o_rdy=1 does not pop in the same cycle.
- i_dat is ignored unless a push occurs. Holding i_vld high while full is legal and loses nothing.
- Ordering: strict FIFO. No word is dropped or duplicated.
- Simulation-only checks (built only when SIMULATION is defined):
  - cnt never exceeds DP.
  - No X on i_vld or o_rdy after reset.

Decomposition:
- No shared package is needed. DW and DP are parameters only, and CW is a localparam derived in the module.
- One sub-module, sirv_gnrl_fifo_ptr (parameter DP). It is a wrap-around pointer register with increment enable and synchronous active-low reset to 0. It is instantiated twice, once for wptr and once for rptr.
- Storage and cnt stay inline.

Test Plan:
- Reset then idle: hold rst_n low for 2 cycles, then release with i_vld=0 and o_rdy=0. Required: o_vld=0, i_rdy=1, cnt=0, empty=1, full=0, o_dat=0 for 5 cycles.
- Fill and drain, DP=4: push 0xA0..0xA3 on consecutive cycles with o_rdy=0.
  - After the 4th push: full=1, i_rdy=0, cnt=4.
  - A 5th i_vld=1 with 0xFF is not accepted.
  - Then set o_rdy=1: reads return 0xA0, 0xA1, 0xA2, 0xA3 in order; after that empty=1 and 0xFF never appears.
- Simultaneous push/pop at cnt=2: stream 20 words with i_vld=1 and o_rdy=1 every cycle. Required: cnt stays 2, output order equals input order, and both pointers wrap at least 4 times.
- Full with o_rdy=1: at cnt=4, assert i_vld=1 and o_rdy=1 in the same cycle. Required: pop only, cnt=3 next cycle, and i_rdy=1 next cycle.
- Empty with i_vld=1 and o_rdy=1: push 0x55. Required: o_vld=0 in that cycle; o_vld=1 and o_dat=0x55 next cycle; cnt goes 0→1→0.
- Reset mid-operation: at cnt=3, pull rst_n low for 1 cycle together with i_vld=1. Required: next cycle cnt=0, o_vld=0, i_rdy=1, o_dat=0. A subsequent push of 0x77 is read back as the first word.
- Random (run with both DP=3 and DP=4): 10k cycles of random i_vld/o_rdy checked against a queue model. Required: no mismatch, and cnt always in 0..DP.
